flash_sdram_loader: RTL

//  Multi-region flash->SDRAM copy engine with optional read-back verify. Walks NUM_REGIONS
//  (flash base, SDRAM base, word count) triples, fetching 16-bit words from the SPI flash

---
 rtl/flash_sdram_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/flash_sdram_loader.sv
// flash_sdram_loader: copies (or read-back verifies) flash regions into SDRAM, one word per slot pair.
module flash_sdram_loader #(
    parameter int NUM_REGIONS = 2,
    parameter int RAM_AW = 20,
    parameter int LEN_W = 17,
    parameter logic [NUM_REGIONS*24-1:0] REGION_FLASH = {24'h70000, 24'h78000},
    parameter logic [NUM_REGIONS*RAM_AW-1:0] REGION_RAM = {20'h04000, 20'h00000},
    parameter logic [NUM_REGIONS*LEN_W-1:0] REGION_LEN = {17'd8192, 17'd16384},
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              verify,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [RAM_AW-1:0] err_addr,
    output logic [15:0]       err_count,
    output logic [2:0]        region,
    output logic              flash_valid,
    input  logic              flash_ready,
    output logic [23:0]       flash_addr,
    input  logic [15:0]       flash_rdata,
    input  logic              ram_sync,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout
);
    typedef enum logic [2:0] {IDLE, SEL, FREQ, WAIT_S1, WAIT_S2, ADV, FIN} state_t;

    state_t state, state_n;
    logic [LEN_W-1:0] idx, len;
    logic [23:0] flash_base;
    logic [RAM_AW-1:0] ram_base;
    logic [15:0] word;
    logic mode, armed, last_region, last_word, ram_req;

    assign flash_base  = REGION_FLASH[region*24 +: 24];
    assign ram_base    = REGION_RAM[region*RAM_AW +: RAM_AW];
    assign len         = REGION_LEN[region*LEN_W +: LEN_W];
    assign last_region = region == 3'(NUM_REGIONS - 1);
    assign last_word   = idx == len - 1'b1;
    assign flash_addr  = flash_base + 24'({idx, 1'b0});
    assign ram_addr    = ram_base + RAM_AW'(idx);
    assign ram_din     = word;
    assign busy        = state != IDLE && state != FIN;
    assign done        = state == FIN;
    assign flash_valid = state == FREQ;
    assign ram_req     = state == WAIT_S1 || state == WAIT_S2;
    assign ram_we      = ram_req & ~mode;
    assign ram_oe      = ram_req & mode;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SEL : IDLE;
            SEL:     state_n = len != '0 ? FREQ : last_region ? FIN : SEL;
            FREQ:    state_n = flash_ready ? WAIT_S1 : FREQ;
            // a sync in the first request cycle cannot have seen the request
            WAIT_S1: state_n = ram_sync && armed ? WAIT_S2 : WAIT_S1;
            WAIT_S2: state_n = ram_sync ? ADV : WAIT_S2;
            ADV:     state_n = (STOP_ON_ERR && error) || (last_word && last_region) ? FIN :
                               last_word ? SEL : FREQ;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode      <= 1'b0;
            armed     <= 1'b0;
            word      <= '0;
            idx       <= '0;
            region    <= '0;
            error     <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            armed <= state == WAIT_S1;
            case (state)
                IDLE: if (start) begin
                    mode      <= verify;
                    error     <= 1'b0;
                    err_addr  <= '0;
                    err_count <= '0;
                    region    <= '0;
                    idx       <= '0;
                end
                SEL:  if (len == '0 && !last_region) region <= region + 3'd1;
                FREQ: if (flash_ready) word <= flash_rdata;
                WAIT_S2: if (ram_sync && mode && ram_dout != word) begin
                    error     <= 1'b1;
                    err_count <= err_count + {15'd0, ~&err_count};
                    if (!error) err_addr <= ram_addr;
                end
                ADV: begin
                    idx <= last_word ? '0 : idx + 1'b1;
                    if (last_word && !last_region) region <= region + 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
